// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle Minisys-1 control unit:
// opcode/funct constants, FSM state type, ALU-op and PC-source encodings
// and the one-hot instruction-class record produced by the decoder.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // All immediate ALU instructions (addi..lui) share opcode[5:3] = 001
    localparam logic [2:0] OP_IFMT_HI = 3'b001;
    // Shift instructions are R-type with funct[5:3] = 000
    localparam logic [2:0] FN_SHIFT_HI = 3'b000;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_RFN = 2'b10;
    localparam logic [1:0] ALU_IFN = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    // Exactly one field is set for any opcode/funct pair
    typedef struct packed {
        logic r_type;
        logic jr;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic i_fmt;
        logic illegal;
    } inst_class_t;

endpackage

// File: rtl/mcycle_ctrl32_if.sv
// Memory request/acknowledge handshake between the control unit (master)
// and the memory subsystem (slave).
interface mcycle_ctrl32_if;

    logic mem_req;
    logic mem_write;
    logic mem_ack;

    modport master (output mem_req, output mem_write, input mem_ack);
    modport slave  (input mem_req, input mem_write, output mem_ack);

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: turns the held IR opcode/funct
// fields into a one-hot class plus a shift-instruction flag.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output inst_class_t cls,
    output logic        is_shift
);

    // Classify the instruction; anything unrecognised is flagged illegal
    always_comb begin
        cls      = '0;
        is_shift = 1'b0;
        if (opcode == OP_RTYPE) begin
            if (funct == FN_JR) begin
                cls.jr = 1'b1;
            end else begin
                cls.r_type = 1'b1;
            end
            is_shift = (funct[5:3] == FN_SHIFT_HI);
        end else if (opcode[5:3] == OP_IFMT_HI) begin
            cls.i_fmt = 1'b1;
        end else begin
            case (opcode)
                OP_LW:   cls.lw      = 1'b1;
                OP_SW:   cls.sw      = 1'b1;
                OP_BEQ:  cls.beq     = 1'b1;
                OP_BNE:  cls.bne     = 1'b1;
                OP_J:    cls.j       = 1'b1;
                OP_JAL:  cls.jal     = 1'b1;
                default: cls.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mcycle_ctrl32.sv
// Multi-cycle Minisys-1 control unit. Sequences each instruction through
// IF/ID/EX/MEM/WB, drives the datapath enables for the current state and
// counts retired instructions.
// Optional feature macro: MC_CTRL_TRAP_EN -- when defined, an illegal opcode
// enters TRAP (trap pulse, jump to vector); otherwise it behaves as a NOP.
module mcycle_ctrl32
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [OPC_W-1:0]   funct,
    mcycle_ctrl32_if.master    mem,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic               nbranch,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               jal,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               i_format,
    output logic               sftmd,
    output logic               jrn,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [CNT_W-1:0]   retired,
    output logic               trap
);

    state_t      state;
    inst_class_t cls;
    logic        is_shift;
    logic        mem_req_c;
    logic        mem_write_c;

    mc_ctrl_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (cls),
        .is_shift (is_shift)
    );

    // Sequence state and count every instruction that finishes into IF
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            retired <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_IF;
                ST_IF: begin
                    if (mem.mem_ack) state <= ST_ID;
                end
                ST_ID: begin
                    if (cls.j) begin
                        state   <= ST_IF;
                        retired <= retired + CNT_W'(1);
                    end else if (cls.jal) begin
                        state <= ST_WB;
                    end else if (cls.illegal) begin
`ifdef MC_CTRL_TRAP_EN
                        state <= ST_TRAP;
`else
                        state   <= ST_IF;
                        retired <= retired + CNT_W'(1);
`endif
                    end else begin
                        state <= ST_EX;
                    end
                end
                ST_EX: begin
                    if (cls.lw || cls.sw) begin
                        state <= ST_MEM;
                    end else if (cls.beq || cls.bne || cls.jr) begin
                        state   <= ST_IF;
                        retired <= retired + CNT_W'(1);
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem.mem_ack) begin
                        if (cls.lw) begin
                            state <= ST_WB;
                        end else begin
                            state   <= ST_IF;
                            retired <= retired + CNT_W'(1);
                        end
                    end
                end
                ST_WB, ST_TRAP: begin
                    state   <= ST_IF;
                    retired <= retired + CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MC_CTRL_TRAP_EN
    logic trap_c;
    assign trap = trap_c;
`else
    assign trap = 1'b0;
`endif

    // Datapath enables decoded from the current state and the held IR
    always_comb begin
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        nbranch     = 1'b0;
        pc_src      = PC_PLUS4;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        jal         = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        i_format    = 1'b0;
        sftmd       = 1'b0;
        jrn         = 1'b0;
        alu_op      = ALU_ADD;
`ifdef MC_CTRL_TRAP_EN
        trap_c      = 1'b0;
`endif
        case (state)
            ST_IF: begin
                mem_req_c = 1'b1;
                ir_write  = mem.mem_ack;
                pc_write  = mem.mem_ack;
            end
            ST_ID: begin
                if (cls.j) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                end
            end
            ST_EX: begin
                if (cls.r_type) begin
                    alu_op = ALU_RFN;
                    sftmd  = is_shift;
                end
                if (cls.i_fmt) begin
                    alu_src  = 1'b1;
                    alu_op   = ALU_IFN;
                    i_format = 1'b1;
                end
                if (cls.lw || cls.sw) begin
                    alu_src = 1'b1;
                end
                if (cls.beq || cls.bne) begin
                    alu_op  = ALU_SUB;
                    branch  = cls.beq;
                    nbranch = cls.bne;
                    pc_src  = PC_BRANCH;
                end
                if (cls.jr) begin
                    jrn      = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_REG;
                end
            end
            ST_MEM: begin
                mem_req_c   = 1'b1;
                mem_write_c = cls.sw;
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = cls.r_type;
                mem_to_reg = cls.lw;
                i_format   = cls.i_fmt;
                if (cls.jal) begin
                    jal      = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                end
            end
            ST_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                trap_c   = 1'b1;
                pc_write = 1'b1;
                pc_src   = PC_REG;
`endif
            end
            default: ;
        endcase
    end

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_write = mem_write_c;

endmodule

// File: tb/tb_mcycle_ctrl32.sv
// Testbench for mcycle_ctrl32. An instruction-level model expands each
// instruction into the list of per-cycle output values it must produce;
// a single compare process checks DUT outputs and the retired count
// against that expectation every cycle. Honours MC_CTRL_TRAP_EN.
module tb_mcycle_ctrl32;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       nbranch;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       jal;
        logic       mem_to_reg;
        logic       alu_src;
        logic       i_format;
        logic       sftmd;
        logic       jrn;
        logic [1:0] alu_op;
        logic       trap;
    } out_t;

    localparam int K_R = 0, K_SH = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
    localparam int K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

    logic        clock;
    logic        reset_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        ir_write, pc_write, branch, nbranch, reg_write, reg_dst, jal;
    logic        mem_to_reg, alu_src, i_format, sftmd, jrn, trap;
    logic [1:0]  pc_src, alu_op;
    logic [31:0] retired;

    mcycle_ctrl32_if mem_bus ();

    mcycle_ctrl32 dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .funct      (funct),
        .mem        (mem_bus),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .nbranch    (nbranch),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .jal        (jal),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .i_format   (i_format),
        .sftmd      (sftmd),
        .jrn        (jrn),
        .alu_op     (alu_op),
        .retired    (retired),
        .trap       (trap)
    );

    out_t        act;
    out_t        exp_out;
    logic [31:0] exp_ret;
    logic        exp_valid;
    int          model_retired;
    int          instr_cycles;
    int          n_checks;
    int          n_pass;

    assign act = {mem_bus.mem_req, mem_bus.mem_write, ir_write, pc_write, branch, nbranch,
                  pc_src, reg_write, reg_dst, jal, mem_to_reg, alu_src, i_format, sftmd,
                  jrn, alu_op, trap};

    // 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h required %h", name, $time, got, want);
        end
    endtask

    // Per-cycle comparison against the model's expectation
    always @(negedge clock) begin
        #2;
        if (exp_valid) begin
            check_output("outputs", 32'(act), 32'(exp_out));
            check_output("retired", retired, exp_ret);
        end
    end

    function automatic logic is_legal(input logic [5:0] o);
        return (o == 6'd0) || (o >= 6'd2 && o <= 6'd5) || (o[5:3] == 3'b001) ||
               (o == 6'd35) || (o == 6'd43);
    endfunction

    task automatic pick(input int kind, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (kind)
            K_R:   begin op = 6'd0; fn = {1'b1, 5'($urandom)}; end
            K_SH:  begin op = 6'd0; fn = {3'b000, 3'($urandom)}; end
            K_I:   op = {3'b001, 3'($urandom)};
            K_LW:  op = 6'b100011;
            K_SW:  op = 6'b101011;
            K_BEQ: op = 6'b000100;
            K_BNE: op = 6'b000101;
            K_J:   op = 6'b000010;
            K_JAL: op = 6'b000011;
            K_JR:  begin op = 6'd0; fn = 6'b001000; end
            default: begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
        endcase
    endtask

    // Drive one clock cycle of stimulus and publish its expected outputs
    task automatic apply_stimulus(input out_t e, input logic ack, input logic [5:0] op,
                                  input logic [5:0] fn);
        @(negedge clock);
        mem_bus.mem_ack = ack;
        opcode          = op;
        funct           = fn;
        exp_out         = e;
        exp_ret         = 32'(model_retired);
        exp_valid       = 1'b1;
        instr_cycles++;
    endtask

    // Assert reset now, confirm outputs clear at once, release on a later
    // falling edge; that cycle is IDLE with everything low
    task automatic apply_reset();
        reset_n         = 1'b0;
        mem_bus.mem_ack = 1'b0;
        exp_valid       = 1'b0;
        #1;
        check_output("reset_outputs", 32'(act), 32'd0);
        check_output("reset_retired", retired, 32'd0);
        repeat (2) @(negedge clock);
        reset_n       = 1'b1;
        model_retired = 0;
        exp_out       = '0;
        exp_ret       = 32'd0;
        exp_valid     = 1'b1;
    endtask

    // Instruction-level model: one instruction expanded into its cycles
    task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                             input int if_wait, input int mem_wait, input int abort_at,
                             output int ncyc);
        out_t e;
        instr_cycles = 0;
        for (int i = 0; i < if_wait; i++) begin
            e = '0; e.mem_req = 1'b1;
            apply_stimulus(e, 1'b0, 6'($urandom), 6'($urandom));
        end
        e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        apply_stimulus(e, 1'b1, 6'($urandom), 6'($urandom));

        e = '0;
        if (kind == K_J) begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
        apply_stimulus(e, 1'($urandom), op, fn);

        if (kind == K_ILL) begin
`ifdef MC_CTRL_TRAP_EN
            e = '0; e.trap = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b11;
            apply_stimulus(e, 1'($urandom), op, fn);
`endif
        end else if (kind != K_J) begin
            if (kind != K_JAL) begin
                e = '0;
                case (kind)
                    K_R:   e.alu_op = 2'b10;
                    K_SH:  begin e.alu_op = 2'b10; e.sftmd = 1'b1; end
                    K_I:   begin e.alu_src = 1'b1; e.alu_op = 2'b11; e.i_format = 1'b1; end
                    K_LW, K_SW: e.alu_src = 1'b1;
                    K_BEQ: begin e.alu_op = 2'b01; e.branch = 1'b1; e.pc_src = 2'b01; end
                    K_BNE: begin e.alu_op = 2'b01; e.nbranch = 1'b1; e.pc_src = 2'b01; end
                    K_JR:  begin e.jrn = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b11; end
                    default: ;
                endcase
                apply_stimulus(e, 1'($urandom), op, fn);
            end
            if (kind == K_LW || kind == K_SW) begin
                for (int i = 0; i <= mem_wait; i++) begin
                    e = '0; e.mem_req = 1'b1; e.mem_write = (kind == K_SW);
                    apply_stimulus(e, (i == mem_wait), op, fn);
                    if (i == abort_at) begin
                        #3;
                        apply_reset();
                        ncyc = instr_cycles;
                        return;
                    end
                end
            end
            if (kind == K_R || kind == K_SH || kind == K_I || kind == K_LW || kind == K_JAL) begin
                e = '0; e.reg_write = 1'b1;
                e.reg_dst    = (kind == K_R || kind == K_SH);
                e.mem_to_reg = (kind == K_LW);
                e.i_format   = (kind == K_I);
                if (kind == K_JAL) begin e.jal = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b10; end
                apply_stimulus(e, 1'($urandom), op, fn);
            end
        end
        model_retired++;
        ncyc = instr_cycles;
    endtask

    initial begin
        int          ncyc;
        int          total;
        int          kind;
        logic [5:0]  op;
        logic [5:0]  fn;
        n_checks        = 0;
        n_pass          = 0;
        model_retired   = 0;
        exp_valid       = 1'b0;
        exp_out         = '0;
        exp_ret         = '0;
        opcode          = '0;
        funct           = '0;
        mem_bus.mem_ack = 1'b0;
        reset_n         = 1'b0;
        apply_reset();

        // add with zero-wait memory: 4 cycles, retired becomes 1
        run_instr(K_R, 6'd0, 6'b100000, 0, 0, -1, ncyc);
        check_output("add_cycles", 32'(ncyc), 32'd4);
        @(posedge clock); #1;
        check_output("add_retired", retired, 32'd1);

        // lw with three wait cycles in MEM: 8 cycles total
        @(negedge clock); apply_reset();
        run_instr(K_LW, 6'b100011, 6'd0, 0, 3, -1, ncyc);
        check_output("lw_cycles", 32'(ncyc), 32'd8);

        // sw then beq: 7 cycles, retired 2
        @(negedge clock); apply_reset();
        run_instr(K_SW, 6'b101011, 6'd0, 0, 0, -1, ncyc);
        total = ncyc;
        run_instr(K_BEQ, 6'b000100, 6'd0, 0, 0, -1, ncyc);
        total += ncyc;
        check_output("sw_beq_cycles", 32'(total), 32'd7);
        @(posedge clock); #1;
        check_output("sw_beq_retired", retired, 32'd2);

        // jumps
        run_instr(K_J, 6'b000010, 6'd0, 0, 0, -1, ncyc);
        check_output("j_cycles", 32'(ncyc), 32'd2);
        run_instr(K_JAL, 6'b000011, 6'd0, 1, 0, -1, ncyc);
        check_output("jal_cycles", 32'(ncyc), 32'd4);
        run_instr(K_JR, 6'd0, 6'b001000, 0, 0, -1, ncyc);
        check_output("jr_cycles", 32'(ncyc), 32'd3);

        // illegal opcode
        run_instr(K_ILL, 6'b111111, 6'd0, 0, 0, -1, ncyc);
`ifdef MC_CTRL_TRAP_EN
        check_output("ill_cycles", 32'(ncyc), 32'd3);
`else
        check_output("ill_cycles", 32'(ncyc), 32'd2);
`endif

        // reset during a MEM wait abandons the access
        run_instr(K_LW, 6'b100011, 6'd0, 0, 5, 1, ncyc);

        // randomized instruction stream with random memory latency
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 10));
            pick(kind, op, fn);
            run_instr(kind, op, fn,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                      -1, ncyc);
        end

        @(negedge clock);
        exp_valid = 1'b0;
        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
